// File: rtl/keypad_scan.sv
// 4x4 keypad scanner/debouncer: drives one-hot active-low columns, debounces whole-matrix scans, publishes ASCII key.
// Outputs update 2 clocks after the column-3 sample edge; no backpressure. Define KEYPAD_SYNC_EN to add a 2-flop row synchronizer.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] key,
  output logic       pressed,
  output logic       key_strobe
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [4:0] NONE = 5'h10;
  localparam logic [7:0] LEGEND [16] = '{
    8'h31, 8'h32, 8'h33, 8'h41, 8'h34, 8'h35, 8'h36, 8'h42,
    8'h37, 8'h38, 8'h39, 8'h43, 8'h2A, 8'h30, 8'h23, 8'h44
  };

  logic [3:0]    row_smp;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [11:0]   snap_part;
  logic [15:0]   snap;
  logic          snap_vld;
  logic [4:0]    enc;
  logic [4:0]    code;
  logic          code_vld;
  logic [4:0]    prev_code;
  logic [4:0]    acc_code;
  logic [SW-1:0] stable;
  logic [SW-1:0] stable_nxt;
  logic          accept;
  logic          sample;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] row_s1;
  logic [3:0] row_s2;

  always_ff @(posedge clk) begin
    row_s1 <= row;
    row_s2 <= row_s1;
  end

  assign row_smp = row_s2;
`else
  assign row_smp = row;
`endif

  assign sample = (dwell == DW'(SCAN_DIV - 1));
  assign col    = ~(4'b0001 << col_idx);

  // Snapshot bit 4c+r holds row r seen while column c was driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell     <= '0;
      col_idx   <= '0;
      snap_part <= '0;
      snap      <= '0;
      snap_vld  <= 1'b0;
    end else begin
      snap_vld <= 1'b0;
      if (sample) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          snap     <= {~row_smp, snap_part};
          snap_vld <= 1'b1;
        end else begin
          snap_part[{col_idx, 2'b00} +: 4] <= ~row_smp;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Key index is row*4+col; lowest index wins when several keys are down.
  always_comb begin
    enc = NONE;
    for (int r = 3; r >= 0; r--) begin
      for (int c = 3; c >= 0; c--) begin
        if (snap[c*4 + r]) enc = 5'(r*4 + c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code     <= NONE;
      code_vld <= 1'b0;
    end else begin
      code_vld <= snap_vld;
      if (snap_vld) code <= enc;
    end
  end

  always_comb begin
    stable_nxt = '0;
    if (code == prev_code) begin
      stable_nxt = (stable == SW'(DEBOUNCE_SCANS - 1)) ? stable : stable + SW'(1);
    end
    accept = code_vld && (stable_nxt == SW'(DEBOUNCE_SCANS - 1)) && (code != acc_code);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_code  <= NONE;
      acc_code   <= NONE;
      stable     <= '0;
      key        <= 8'h00;
      pressed    <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (code_vld) begin
        prev_code <= code;
        stable    <= stable_nxt;
        if (accept) begin
          acc_code <= code;
          if (code == NONE) begin
            pressed <= 1'b0;
          end else begin
            key        <= LEGEND[code[3:0]];
            pressed    <= 1'b1;
            key_strobe <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: directed scenarios then random key sets, checked every cycle against a scan-level model.
module tb_keypad_scan;

  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 4 * SD;
  localparam logic [4:0] NONE = 5'd16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] key;
  logic       pressed;
  logic       key_strobe;

  logic [15:0] cur_set = 16'h0000;
  logic [15:0] pending = 16'h0000;
  int tests = 0;
  int fails = 0;
  int t = 0;
  int run = 1;
  logic [4:0] last_code = NONE;
  logic [4:0] acc = NONE;
  logic [7:0] exp_key = 8'h00;
  logic       exp_pressed = 1'b0;
  logic       exp_strobe = 1'b0;
  logic [7:0] legend [16] = '{
    8'h31, 8'h32, 8'h33, 8'h41, 8'h34, 8'h35, 8'h36, 8'h42,
    8'h37, 8'h38, 8'h39, 8'h43, 8'h2A, 8'h30, 8'h23, 8'h44
  };

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key(key), .pressed(pressed), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Keypad model: a held key shorts its row to its column while that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int i = 0; i < 16; i++) begin
      if (cur_set[i] && !col[i % 4]) row[i / 4] = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h at t=%0d", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    run = 1;
    last_code = NONE;
    acc = NONE;
    exp_key = 8'h00;
    exp_pressed = 1'b0;
    exp_strobe = 1'b0;
  endtask

  // One completed scan: lowest pressed index, accepted once seen DB scans in a row.
  task automatic model_scan(input logic [15:0] s);
    logic [4:0] c;
    c = NONE;
    for (int i = 15; i >= 0; i--) if (s[i]) c = 5'(i);
    if (c == last_code) run++;
    else begin
      last_code = c;
      run = 1;
    end
    if (run >= DB && c != acc) begin
      acc = c;
      if (c == NONE) exp_pressed = 1'b0;
      else begin
        exp_key = legend[c[3:0]];
        exp_pressed = 1'b1;
        exp_strobe = 1'b1;
      end
    end
  endtask

  task automatic one_cycle();
    logic [3:0] ec;
    @(negedge clk);
    t++;
    exp_strobe = 1'b0;
    if (t >= SCAN + 2 && t % SCAN == 2) model_scan(pending);
    ec = ~(4'b0001 << ((t / SD) % 4));
    check("col", {4'h0, col}, {4'h0, ec});
    check("key", key, exp_key);
    check("pressed", {7'h0, pressed}, {7'h0, exp_pressed});
    check("key_strobe", {7'h0, key_strobe}, {7'h0, exp_strobe});
    if (t % SCAN == 0) pending = cur_set;
  endtask

  task automatic scan(input logic [15:0] s, input int n);
    repeat (n) begin
      cur_set = s;
      repeat (SCAN) one_cycle();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", {4'h0, col}, 8'h0E);
    check("rst_key", key, 8'h00);
    check("rst_pressed", {7'h0, pressed}, 8'h00);
    check("rst_strobe", {7'h0, key_strobe}, 8'h00);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    int sel;
    do_reset();
    scan(16'h0020, 4);   // '5' held from reset release
    scan(16'h0000, 3);   // release
    scan(16'h0400, 1);   // '9' bounce for one scan
    scan(16'h0000, 2);
    scan(16'h9000, 3);   // '*' + 'D' chord
    scan(16'h0000, 2);
    scan(16'h0001, 3);   // '1'
    scan(16'h4000, 3);   // straight to '#'
    scan(16'h0000, 2);

    scan(16'h0008, 1);
    repeat (7) one_cycle();
    do_reset();

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       s = 16'h0000;
        4:       s = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        5:       s = 16'($urandom);
        default: s = 16'h0001 << $urandom_range(0, 15);
      endcase
      scan(s, $urandom_range(1, 3));
    end
    scan(16'h0000, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
